// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared flit-type encodings, widths and transmitter FSM states
//               for the router link transmitter.
// Revision    : 1.0  initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_W = 17;
    localparam int TYPE_W = 2;

    // Flit type lives in the two most significant bits of every flit.
    typedef enum logic [TYPE_W-1:0] {
        FLIT_SINGLE = 2'b00,   // head and tail in one flit
        FLIT_HEAD   = 2'b01,
        FLIT_BODY   = 2'b10,
        FLIT_TAIL   = 2'b11
    } flit_type_e;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_PKT  = 1'b1
    } tx_state_e;

endpackage : noc_pkg
`default_nettype wire

// File: rtl/link_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : link_tx_if
// Description : Bundle of the upstream (local output register) handshake and
//               the downstream link signals of a router output port.
//   up_data_i  : flit presented by the local output register
//   up_valid_i : local register holds a valid flit
//   up_pop_o   : consume the current flit (send strobe)
//   tx_flit_o  : registered flit on the link
//   tx_valid_o : tx_flit_o valid this cycle
//   credit_i   : one pulse per downstream slot freed
//   Modport slave is the transmitter; master is its environment.
// Revision    : 1.0  initial release
// ============================================================================
interface link_tx_if #(
    parameter int DATA_WIDTH = 17
);
    logic [DATA_WIDTH-1:0] up_data_i;
    logic                  up_valid_i;
    logic                  up_pop_o;
    logic [DATA_WIDTH-1:0] tx_flit_o;
    logic                  tx_valid_o;
    logic                  credit_i;

    modport slave (
        input  up_data_i,
        input  up_valid_i,
        input  credit_i,
        output up_pop_o,
        output tx_flit_o,
        output tx_valid_o
    );

    modport master (
        output up_data_i,
        output up_valid_i,
        output credit_i,
        input  up_pop_o,
        input  tx_flit_o,
        input  tx_valid_o
    );
endinterface : link_tx_if
`default_nettype wire

// File: rtl/credit_counter.sv
`default_nettype none
// ============================================================================
// Module      : credit_counter
// Description : Saturating up/down credit counter. Resets to BUF_DEPTH
//               (all downstream slots free). dec consumes one credit, inc
//               returns one; both together leave the count unchanged.
//               A return while already full saturates and pulses overflow.
//   clk, rst   : clock, synchronous active-high reset
//   dec        : a flit was forwarded this cycle
//   inc        : a downstream slot was freed this cycle
//   count      : current credit count
//   overflow   : single-cycle pulse on an over-return
// Revision    : 1.0  initial release
// ============================================================================
module credit_counter #(
    parameter int BUF_DEPTH = 4,
    parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             dec,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] count,
    output logic                  overflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(BUF_DEPTH);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= MAX_CNT;
        end else if (dec && !inc) begin
            // Callers only decrement with a nonzero count.
            count_q <= count_q - 1'b1;
        end else if (inc && !dec && (count_q != MAX_CNT)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count    = count_q;
    assign overflow = !rst && inc && !dec && (count_q == MAX_CNT);

endmodule : credit_counter
`default_nettype wire

// File: rtl/link_tx.sv
`default_nettype none
// ============================================================================
// Module      : link_tx
// Description : Output-side transmitter of a router port. Pulls flits from
//               the local output register, enforces head/body/tail framing,
//               tracks downstream credits and registers flits onto the link.
//   clk, rst   : clock, synchronous active-high reset
//   lnk        : upstream handshake + link signals (link_tx_if.slave)
//   credits_o  : current credit count
//   busy_o     : a packet is in progress
//   err_o      : sticky protocol/credit error, cleared only by reset
// Revision    : 1.0  initial release
// ============================================================================
module link_tx
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = FLIT_W,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_W      = $clog2(BUF_DEPTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    link_tx_if.slave              lnk,
    output logic      [CNT_W-1:0] credits_o,
    output logic                  busy_o,
    output logic                  err_o
);

    tx_state_e             state;
    tx_state_e             state_next;
    flit_type_e            flit_type;
    logic                  can_send;
    logic                  forward;
    logic                  proto_err;
    logic                  overflow;
    logic [CNT_W-1:0]      credits;
    logic [DATA_WIDTH-1:0] tx_flit;
    logic                  tx_valid;
    logic                  err;

    assign flit_type = flit_type_e'(lnk.up_data_i[DATA_WIDTH-1 -: TYPE_W]);

    // Uses the registered count: a credit arriving at zero enables a pop
    // only from the following cycle.
    assign can_send     = lnk.up_valid_i && (credits != '0) && !rst;
    assign lnk.up_pop_o = can_send;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= TX_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Popped flits that break framing in IDLE are dropped: popped but not
    // forwarded, so they cost no credit. Out-of-place HEAD/SINGLE in PKT are
    // still forwarded and restart framing.
    always_comb begin
        state_next = state;
        forward    = 1'b0;
        proto_err  = 1'b0;
        if (can_send) begin
            case (state)
                TX_IDLE: begin
                    case (flit_type)
                        FLIT_SINGLE: forward = 1'b1;
                        FLIT_HEAD: begin
                            forward    = 1'b1;
                            state_next = TX_PKT;
                        end
                        default: proto_err = 1'b1;
                    endcase
                end
                TX_PKT: begin
                    forward = 1'b1;
                    case (flit_type)
                        FLIT_BODY:   state_next = TX_PKT;
                        FLIT_TAIL:   state_next = TX_IDLE;
                        FLIT_HEAD: begin
                            proto_err  = 1'b1;
                            state_next = TX_PKT;
                        end
                        default: begin
                            proto_err  = 1'b1;
                            state_next = TX_IDLE;
                        end
                    endcase
                end
                default: state_next = TX_IDLE;
            endcase
        end
    end

    credit_counter #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .dec      (forward),
        .inc      (lnk.credit_i),
        .count    (credits),
        .overflow (overflow)
    );

    // Link output register; the flit holds its last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_flit  <= '0;
            tx_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            tx_valid <= forward;
            if (forward) begin
                tx_flit <= lnk.up_data_i;
            end
            if (proto_err || overflow) begin
                err <= 1'b1;
            end
        end
    end

    assign lnk.tx_flit_o  = tx_flit;
    assign lnk.tx_valid_o = tx_valid;
    assign credits_o      = credits;
    assign busy_o         = (state == TX_PKT);
    assign err_o          = err;

endmodule : link_tx
`default_nettype wire

// File: tb/tb_link_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_link_tx
// Description : Self-checking bench for link_tx: directed scenarios with
//               literal expectations plus randomized traffic, all compared
//               against a transaction-level model of the transmitter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_link_tx;
    import noc_pkg::*;

    localparam int DW    = 17;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] credits;
    logic          busy;
    logic          err;

    link_tx_if #(.DATA_WIDTH(DW)) bus ();

    link_tx #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lnk       (bus),
        .credits_o (credits),
        .busy_o    (busy),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model state: packet open?, credits, sticky error, last link word.
    bit          m_pkt   = 0;
    int          m_cred  = DEPTH;
    bit          m_err   = 0;
    bit          m_valid = 0;
    logic [DW-1:0] m_flit = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int pl);
        logic [DW-1:0] f;
        f = {t, 15'(pl)};
        return f;
    endfunction

    // One clock: drive, check pop, advance model, check registered outputs.
    task automatic cycle(input bit r, input bit v, input logic [DW-1:0] d, input bit c);
        bit         pop, drop, fwd;
        logic [1:0] t;
        rst            = r;
        bus.up_valid_i = v;
        bus.up_data_i  = d;
        bus.credit_i   = c;
        #1;
        pop = v && (m_cred != 0) && !r;
        chk("up_pop", 32'(bus.up_pop_o), 32'(pop));
        t = d[DW-1:DW-2];
        if (r) begin
            m_pkt = 0; m_cred = DEPTH; m_err = 0; m_valid = 0; m_flit = '0;
        end else begin
            drop = pop && !m_pkt && (t == 2'b10 || t == 2'b11);
            fwd  = pop && !drop;
            if (drop) m_err = 1;
            if (fwd && m_pkt && (t == 2'b00 || t == 2'b01)) m_err = 1;
            if (fwd) begin
                m_pkt  = (t == 2'b01) || (t == 2'b10);
                m_flit = d;
            end
            if (fwd && !c) m_cred--;
            else if (!fwd && c) begin
                if (m_cred == DEPTH) m_err = 1;
                else m_cred++;
            end
            m_valid = fwd;
        end
        @(posedge clk);
        #1;
        chk("tx_valid", 32'(bus.tx_valid_o), 32'(m_valid));
        chk("tx_flit", 32'(bus.tx_flit_o), 32'(m_flit));
        chk("credits", 32'(credits), 32'(m_cred));
        chk("busy", 32'(busy), 32'(m_pkt));
        chk("err", 32'(err), 32'(m_err));
    endtask

    initial begin
        bus.up_valid_i = 1'b0;
        bus.up_data_i  = '0;
        bus.credit_i   = 1'b0;
        @(posedge clk);
        #1;

        // Reset and idle state.
        cycle(1, 0, '0, 0);
        chk("rst_credits", 32'(credits), 32'd4);
        chk("rst_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pop", 32'(bus.up_pop_o), 32'd0);

        // HEAD, BODY, TAIL packet.
        cycle(0, 1, mk(2'b01, 1), 0);
        chk("pkt_busy_head", 32'(busy), 32'd1);
        chk("pkt_flit_head", 32'(bus.tx_flit_o), 32'h08001);
        cycle(0, 1, mk(2'b10, 2), 0);
        cycle(0, 1, mk(2'b11, 3), 0);
        chk("pkt_flit_tail", 32'(bus.tx_flit_o), 32'h18003);
        chk("pkt_credits", 32'(credits), 32'd1);
        chk("pkt_busy_tail", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, 1);

        // Five SINGLEs against four credits.
        for (int i = 0; i < 5; i++) cycle(0, 1, mk(2'b00, 16 + i), 0);
        chk("zero_credits", 32'(credits), 32'd0);
        chk("zero_valid", 32'(bus.tx_valid_o), 32'd0);
        cycle(0, 1, mk(2'b00, 20), 1);
        chk("credit_back", 32'(credits), 32'd1);
        cycle(0, 1, mk(2'b00, 20), 0);
        chk("fifth_sent", 32'(bus.tx_flit_o), 32'h00014);
        chk("fifth_credits", 32'(credits), 32'd0);

        // Simultaneous send and credit, then overflow.
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        cycle(0, 1, mk(2'b00, 7), 1);
        chk("send_and_credit", 32'(credits), 32'd2);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        cycle(0, 0, '0, 1);
        chk("overflow_credits", 32'(credits), 32'd4);
        chk("overflow_err", 32'(err), 32'd1);

        // BODY in IDLE is popped and dropped.
        cycle(1, 0, '0, 0);
        cycle(0, 1, mk(2'b10, 5), 0);
        chk("drop_valid", 32'(bus.tx_valid_o), 32'd0);
        chk("drop_credits", 32'(credits), 32'd4);
        chk("drop_err", 32'(err), 32'd1);
        chk("drop_busy", 32'(busy), 32'd0);

        // Reset mid-packet.
        cycle(1, 0, '0, 0);
        cycle(0, 1, mk(2'b01, 9), 0);
        chk("mid_credits", 32'(credits), 32'd3);
        cycle(1, 1, mk(2'b10, 10), 0);
        chk("mid_rst_credits", 32'(credits), 32'd4);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(bus.tx_valid_o), 32'd0);
        cycle(0, 1, mk(2'b10, 11), 0);
        chk("orphan_err", 32'(err), 32'd1);
        chk("orphan_valid", 32'(bus.tx_valid_o), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(99) < 2), ($urandom_range(99) < 70),
                  mk(2'($urandom_range(3)), int'($urandom_range(32767))),
                  ($urandom_range(99) < 35));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_link_tx
`default_nettype wire
